// File: rtl/seg595_frame_monitor.sv
// Passive receive-side decoder for the 2x74HC595 8-digit display bus.
// Optional macro SEG595_MON_SYNC_EN adds 2-flop input synchronizers.
module seg595_frame_monitor #(
  parameter int NUM_DIGITS = 8,
  parameter int FRAME_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dio,
  input  logic                    sclk,
  input  logic                    rclk,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dps,
  output logic                    frame_valid,
  output logic [$clog2(NUM_DIGITS)-1:0] frame_idx,
  output logic                    frame_err,
  output logic                    sel_err,
  output logic                    seg_err
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic w_dio_in, w_sclk_in, w_rclk_in;

`ifdef SEG595_MON_SYNC_EN
  logic [1:0] r_dio_m, r_sclk_m, r_rclk_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dio_m  <= '0;
      r_sclk_m <= '0;
      r_rclk_m <= '0;
    end else begin
      r_dio_m  <= {r_dio_m[0], dio};
      r_sclk_m <= {r_sclk_m[0], sclk};
      r_rclk_m <= {r_rclk_m[0], rclk};
    end
  end

  assign w_dio_in  = r_dio_m[1];
  assign w_sclk_in = r_sclk_m[1];
  assign w_rclk_in = r_rclk_m[1];
`else
  assign w_dio_in  = dio;
  assign w_sclk_in = sclk;
  assign w_rclk_in = rclk;
`endif

  logic r_dio_s, r_sclk_s, r_rclk_s, r_sclk_d, r_rclk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dio_s  <= 1'b0;
      r_sclk_s <= 1'b0;
      r_rclk_s <= 1'b0;
      r_sclk_d <= 1'b0;
      r_rclk_d <= 1'b0;
    end else begin
      r_dio_s  <= w_dio_in;
      r_sclk_s <= w_sclk_in;
      r_rclk_s <= w_rclk_in;
      r_sclk_d <= r_sclk_s;
      r_rclk_d <= r_rclk_s;
    end
  end

  // Returns {unknown, code}; unknown patterns decode to E.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: return 5'h00;
      7'b0110000: return 5'h01;
      7'b1101101: return 5'h02;
      7'b1111001: return 5'h03;
      7'b0110011: return 5'h04;
      7'b1011011: return 5'h05;
      7'b1011111: return 5'h06;
      7'b1110000: return 5'h07;
      7'b1111111: return 5'h08;
      7'b1111011: return 5'h09;
      7'b0000001: return 5'h0F;
      default:    return 5'h1E;
    endcase
  endfunction

  logic [FRAME_BITS-1:0] r_sr, w_sr_next;
  logic [4:0]            r_cnt, w_cnt_next;
  logic                  w_sclk_rise, w_rclk_rise;
  logic [7:0]            w_sel, w_seg;
  logic                  w_sel_ok;
  logic [IDX_W-1:0]      w_idx;
  logic [4:0]            w_dec;

  assign w_sclk_rise = r_sclk_s & ~r_sclk_d;
  assign w_rclk_rise = r_rclk_s & ~r_rclk_d;

  // Frame check sees the post-shift state so coincident sclk/rclk edges count the bit.
  assign w_sr_next  = w_sclk_rise ? {r_sr[FRAME_BITS-2:0], r_dio_s} : r_sr;
  assign w_cnt_next = (w_sclk_rise && r_cnt != 5'd31) ? r_cnt + 5'd1 : r_cnt;

  assign w_sel    = w_sr_next[FRAME_BITS-1 -: 8];
  assign w_seg    = w_sr_next[7:0];
  assign w_sel_ok = ($countones(~w_sel) == 1);
  assign w_dec    = decode(w_seg[6:0]);

  always_comb begin
    w_idx = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++)
      if (!w_sel[k]) w_idx = IDX_W'(k);
  end

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dps;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_fv, r_fe, r_se, r_ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_digits <= '1;
      r_dps    <= '0;
      r_idx    <= '0;
      r_fv     <= 1'b0;
      r_fe     <= 1'b0;
      r_se     <= 1'b0;
      r_ge     <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      r_fe <= 1'b0;
      r_se <= 1'b0;
      r_ge <= 1'b0;
      r_sr <= w_sr_next;
      if (w_rclk_rise) begin
        r_cnt <= '0;
        if (w_cnt_next != 5'(FRAME_BITS)) begin
          r_fe <= 1'b1;
        end else if (!w_sel_ok) begin
          r_se <= 1'b1;
        end else begin
          r_digits[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
          r_dps[w_idx] <= w_seg[7];
          r_idx        <= w_idx;
          r_fv         <= 1'b1;
          r_ge         <= w_dec[4];
        end
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign digits      = r_digits;
  assign dps         = r_dps;
  assign frame_idx   = r_idx;
  assign frame_valid = r_fv;
  assign frame_err   = r_fe;
  assign sel_err     = r_se;
  assign seg_err     = r_ge;

endmodule
